fifo_wr_arbiter: RTL

- Round-robin write-port arbiter that lets NUM_REQ producers share the single write port of one FIFO1 instance: wr_en, data_i and full_o.
- Grants one requester at a time, with a burst cap so no requester starves the others.
- Obeys the FIFO's full back-pressure and keeps a saturating stall counter for performance debug.
- Sits between the operand producers and the GCD input FIFO.

---
 rtl/gcd_arb_pkg.sv | 11 +
 rtl/fifo_wr_arbiter_if.sv | 23 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/gcd_arb_pkg.sv
// Shared types and helpers for the GCD input-FIFO write arbiter.
package gcd_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;

  // Index width for a vector of n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake plus the FIFO write port seen by the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4
);
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          fifo_full_i;
  logic                          fifo_wr_en_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic [NUM_REQ-1:0]            grant_o;

  modport master (
    input  req_valid_i, req_data_i, fifo_full_i,
    output req_ready_o, fifo_wr_en_o, fifo_data_o, grant_o
  );

  modport slave (
    output req_valid_i, req_data_i, fifo_full_i,
    input  req_ready_o, fifo_wr_en_o, fifo_data_o, grant_o
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first valid index at or after start_i, with wrap.
module rr_pick
  import gcd_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IW-1:0]      start_i,
  output logic               found_o,
  output logic [IW-1:0]      idx_o
);

  logic [IW-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  // Position gi of the rotated view is the requester gi steps past the pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign cand_idx[gi] = IW'((int'(start_i) + gi) % NUM_REQ);
      assign cand_hit[gi] = valid_i[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        found_o = 1'b1;
        idx_o   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-capped arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 4,
  parameter int STALL_W    = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fifo_wr_arbiter_if.master  bus,
  output logic [STALL_W-1:0] stall_cnt_o
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int BW = idx_w(MAX_BURST);

  arb_state_e         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]      burst_q, burst_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic               idle_found, rel_found;
  logic [IW-1:0]      idle_idx, rel_idx, owner_inc;
  logic               owner_valid, full, rel_en;
  logic [NUM_REQ-1:0] ready, grant;
  logic               wr_en;
  logic [DATA_WIDTH-1:0] data;

  assign full        = bus.fifo_full_i;
  assign owner_valid = bus.req_valid_i[owner_q];
  assign owner_inc   = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_idle_pick (
    .valid_i (bus.req_valid_i),
    .start_i (rr_ptr_q),
    .found_o (idle_found),
    .idx_o   (idle_idx)
  );

  // Release pick starts just past the current owner, so it sees the pointer being written.
  rr_pick #(.NUM_REQ(NUM_REQ)) u_rel_pick (
    .valid_i (bus.req_valid_i),
    .start_i (owner_inc),
    .found_o (rel_found),
    .idx_o   (rel_idx)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    burst_d  = burst_q;
    stall_d  = stall_q;
    ready    = '0;
    grant    = '0;
    wr_en    = 1'b0;
    data     = '0;
    rel_en   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (idle_found) begin
          state_d = ARB_OWN;
          owner_d = idle_idx;
          burst_d = '0;
        end
      end
      ARB_OWN: begin
        grant[owner_q] = 1'b1;
        ready[owner_q] = !full;
        wr_en          = owner_valid && !full;
        data           = bus.req_data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];

        // A dropped valid wins over full: release without counting a stall.
        if (!owner_valid) begin
          rel_en = 1'b1;
        end else if (full) begin
          if (stall_q != '1) stall_d = stall_q + 1'b1;
        end else if (int'(burst_q) + 1 < MAX_BURST) begin
          burst_d = burst_q + 1'b1;
        end else begin
          rel_en = 1'b1;
        end

        if (rel_en) begin
          rr_ptr_d = owner_inc;
          burst_d  = '0;
          if (rel_found) owner_d = rel_idx;
          else           state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      burst_q  <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      burst_q  <= burst_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.req_ready_o  = ready;
  assign bus.grant_o      = grant;
  assign bus.fifo_wr_en_o = wr_en;
  assign bus.fifo_data_o  = data;
  assign stall_cnt_o      = stall_q;

endmodule
